hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised successor to the single-cycle load-use detector in the decode stage. It tracks every architectural register with a per-register countdown of cycles until its pending result is forwardable. Decode is stalled on RAW hazards against loads, multi-cycle multiplies, or any future variable-latency class. It also freezes on memory-busy, tolerates the late store-data read, resolves WAW overlap, and counts stall cycles for performance analysis.

Parameters:
REG_ADDR, `REG_ADDR (5), register address width
NUM_REGS, 32, number of scoreboard entries (must equal 2**REG_ADDR)
LAT_W, 3, width of each countdown counter
LOAD_LAT, 1, cycles a load result is unavailable to a dependent in D (1 gives classic load-use)
MUL_LAT, 4, cycles a multiply result is unavailable
PERF_W, 32, stall-cycle counter width

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high
id_valid  in  1  D stage holds a real instruction
id_reg_addr1  in  REG_ADDR  D-stage source register 1
id_reg_addr2  in  REG_ADDR  D-stage source register 2
id_uses_rs1  in  1  instruction reads source 1
id_uses_rs2  in  1  instruction reads source 2
id_store  in  1  instruction is a store; source 2 is consumed in MEM
id_writes_reg  in  1  instruction writes id_dst_reg
id_dst_reg  in  REG_ADDR  destination register
id_class  in  2  0=ALU, 1=LOAD, 2=MUL, 3=reserved (treated as ALU)
flush  in  1  D-stage instruction is squashed this cycle
mem_busy  in  1  D-cache miss; whole pipeline frozen
stall  out  1  hold PC and IF/ID; inject bubble into ID/EX
busy_vec  out  NUM_REGS  bit r set when cnt[r] != 0
stall_cycles  out  PERF_W  saturating count of cycles with stall=1

Behaviour:
- State: cnt[0..NUM_REGS-1] (LAT_W bits each) and stall_cycles.
- Reset (synchronous): all cnt=0 and stall_cycles=0. The resulting stall is 0 unless mem_busy=1. busy_vec=0.
- lat(class): ALU/reserved→0, LOAD→LOAD_LAT, MUL→MUL_LAT. Both values are truncated-checked: LOAD_LAT and MUL_LAT must be < 2**LAT_W. Elaboration error otherwise.
- Hazard, combinational:
  - h1 = id_uses_rs1 && rs1!=0 && cnt[rs1]!=0
  - h2 = id_uses_rs2 && rs2!=0 && cnt[rs2] > (id_store ? 1 : 0)
- stall = mem_busy || (id_valid && !flush && (h1 || h2)). This is combinational from inputs and state, with no added latency.
- issue = id_valid && !flush && !stall.
- Per clock edge, when mem_busy=1: all cnt hold.
- Per clock edge, when mem_busy=0:
  - every nonzero cnt decrements by 1;
  - if issue && id_writes_reg && id_dst_reg!=0 then cnt[dst] <= max(cnt[dst]-1 saturating at 0, lat(class)). This resolves WAW: the longer pending result wins.
  - An ALU issue to a register with cnt=0 leaves it 0.
- Register 0 is never busy. Writes to r0 are ignored, and cnt[0] stays 0.
- Source equal to destination of the same instruction: the hazard is evaluated on the pre-issue cnt only.
- A flush in the stall cycle drops the stall for that instruction (squashed, no issue). Counters of already-issued instructions keep counting.
- stall_cycles increments on every cycle with stall=1 and saturates at all-ones.
- With LOAD_LAT=1 and MUL never used, the block is cycle-equivalent to the one-cycle load-use detector:
  - load in EX plus dependent in D gives exactly one stall;
  - a store whose rs2 is the load target gives no stall.
- Reset asserted mid-countdown clears all entries on that edge. The next cycle shows no hazards.

Decomposition:
- Shared package/define header holds:
  - REG_ADDR
  - class encodings CLS_ALU/CLS_LOAD/CLS_MUL
  - default LOAD_LAT/MUL_LAT
- One natural sub-module, sb_entry: a single LAT_W countdown with load/max/decrement/freeze. It is instantiated NUM_REGS times by generate; entry 0 is tied to 0.

Test Plan:
1. Load r3 issues, next D instr `add r4,r3,r1` → stall=1 for exactly 1 cycle, then issue; stall_cycles=1.
2. Load r3, next D instr `sw r3,0(r5)` (rs2=r3, id_store=1) → stall=0. If instead r3 is the base (rs1) → 1 stall.
3. MUL r7 (MUL_LAT=4), immediate dependent on r7 → stall for 4 consecutive cycles; busy_vec[7] falls on the cycle issue occurs.
4. MUL r7 then mem_busy held 3 cycles mid-countdown → cnt[7] frozen and stall=1 throughout; total stall extends by 3.
5. MUL r2 followed next cycle by load r2 (WAW) → cnt[2] = max(3,1)=3; a dependent stalls 3 cycles. Load to r0 → busy_vec[0] stays 0, no stall.
6. Reset asserted while cnt[5]=2 with a dependent in D → after the edge busy_vec=0, stall=0, stall_cycles=0. Flush during a hazard → stall deasserts that cycle.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard: register address
// width, instruction latency classes and default result latencies.
package hazard_scoreboard_pkg;

    localparam int SB_REG_ADDR  = 5;
    localparam int DEF_LOAD_LAT = 1;
    localparam int DEF_MUL_LAT  = 4;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_MUL  = 2'd2,
        CLS_RSVD = 2'd3
    } instr_class_e;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard entry: countdown of cycles until a pending register result
// becomes forwardable, with freeze, decrement and max-merge on a new writer.
module sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             freeze,
    input  logic             load_en,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] count
);

    logic [LAT_W-1:0] dec_val;
    logic [LAT_W-1:0] next_val;

    assign dec_val = (count != '0) ? count - 1'b1 : '0;

    // A new writer only lengthens the wait: the later-completing result wins WAW.
    assign next_val = (load_en && load_val > dec_val) ? load_val : dec_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (!freeze) begin
            count <= next_val;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard scoreboard: per-register countdowns, stall generation
// with memory-busy freeze, late store-data tolerance and a stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR = SB_REG_ADDR,
    parameter int NUM_REGS = 32,
    parameter int LAT_W    = 3,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int MUL_LAT  = DEF_MUL_LAT,
    parameter int PERF_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_ADDR-1:0] id_reg_addr1,
    input  logic [REG_ADDR-1:0] id_reg_addr2,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic                id_store,
    input  logic                id_writes_reg,
    input  logic [REG_ADDR-1:0] id_dst_reg,
    input  logic [1:0]          id_class,
    input  logic                flush,
    input  logic                mem_busy,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [PERF_W-1:0]   stall_cycles
);

    if (NUM_REGS != (1 << REG_ADDR)) begin : g_bad_num_regs
        $error("hazard_scoreboard: NUM_REGS must equal 2**REG_ADDR");
    end
    if (LOAD_LAT >= (1 << LAT_W)) begin : g_bad_load_lat
        $error("hazard_scoreboard: LOAD_LAT does not fit in LAT_W bits");
    end
    if (MUL_LAT >= (1 << LAT_W)) begin : g_bad_mul_lat
        $error("hazard_scoreboard: MUL_LAT does not fit in LAT_W bits");
    end

    function automatic logic [LAT_W-1:0] class_lat(input logic [1:0] cls);
        case (instr_class_e'(cls))
            CLS_LOAD: return LAT_W'(LOAD_LAT);
            CLS_MUL:  return LAT_W'(MUL_LAT);
            default:  return '0;
        endcase
    endfunction

    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic [LAT_W-1:0] dst_lat;
    logic [LAT_W-1:0] rs2_thresh;
    logic             h1;
    logic             h2;
    logic             issue;
    logic             dst_write;

    // Store data is read in MEM, one cycle later, so a count of 1 is already safe.
    assign rs2_thresh = id_store ? LAT_W'(1) : '0;

    assign h1 = id_uses_rs1 && (id_reg_addr1 != '0) && (cnt[id_reg_addr1] != '0);
    assign h2 = id_uses_rs2 && (id_reg_addr2 != '0) && (cnt[id_reg_addr2] > rs2_thresh);

    assign stall     = mem_busy || (id_valid && !flush && (h1 || h2));
    assign issue     = id_valid && !flush && !stall;
    assign dst_write = issue && id_writes_reg;
    assign dst_lat   = class_lat(id_class);

    assign cnt[0]      = '0;
    assign busy_vec[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .clk      (clk),
            .reset    (reset),
            .freeze   (mem_busy),
            .load_en  (dst_write && (id_dst_reg == REG_ADDR'(r))),
            .load_val (dst_lat),
            .count    (cnt[r])
        );
        assign busy_vec[r] = (cnt[r] != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_reg_addr1;
    logic [4:0]  id_reg_addr2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        id_store;
    logic        id_writes_reg;
    logic [4:0]  id_dst_reg;
    logic [1:0]  id_class;
    logic        flush;
    logic        mem_busy;
    logic        stall;
    logic [31:0] busy_vec;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_reg_addr1  (id_reg_addr1),
        .id_reg_addr2  (id_reg_addr2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .id_store      (id_store),
        .id_writes_reg (id_writes_reg),
        .id_dst_reg    (id_dst_reg),
        .id_class      (id_class),
        .flush         (flush),
        .mem_busy      (mem_busy),
        .stall         (stall),
        .busy_vec      (busy_vec),
        .stall_cycles  (stall_cycles)
    );

    typedef struct {
        int          tag;
        logic        st;
        logic [31:0] bv;
        logic [31:0] sc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    localparam logic [1:0] ALU = 2'd0, LD = 2'd1, MUL = 2'd2;

    function automatic logic [31:0] b(input int r);
        return 32'h1 << r;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic st,
                         input logic wr, input logic [4:0] dst, input logic [1:0] cls,
                         input logic fl, input logic mb);
        id_valid = v; id_reg_addr1 = rs1; id_uses_rs1 = u1;
        id_reg_addr2 = rs2; id_uses_rs2 = u2; id_store = st;
        id_writes_reg = wr; id_dst_reg = dst; id_class = cls;
        flush = fl; mem_busy = mb;
    endtask

    task automatic idle(input logic mb);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, ALU, 1'b0, mb);
    endtask

    // producer writing dst with class cls, no sources
    task automatic prod(input logic [4:0] dst, input logic [1:0] cls);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, dst, cls, 1'b0, 1'b0);
    endtask

    // ALU consumer of rs1 writing dst
    task automatic dep(input logic [4:0] rs1, input logic [4:0] dst, input logic fl,
                       input logic mb);
        drive(1'b1, rs1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, dst, ALU, fl, mb);
    endtask

    task automatic chk(input logic st, input logic [31:0] bv, input logic [31:0] sc);
        exp_t e;
        cyc++;
        e.tag = cyc; e.st = st; e.bv = bv; e.sc = sc;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (stall !== e.st) begin
                errors++;
                $display("FAIL stall@c%0d: got %b expected %b", e.tag, stall, e.st);
            end
            checks++;
            if (busy_vec !== e.bv) begin
                errors++;
                $display("FAIL busy_vec@c%0d: got %h expected %h", e.tag, busy_vec, e.bv);
            end
            checks++;
            if (stall_cycles !== e.sc) begin
                errors++;
                $display("FAIL stall_cycles@c%0d: got %0d expected %0d", e.tag, stall_cycles, e.sc);
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk(0, 0, 0);                       // reset state
        reset = 1'b0;

        // load-use: one stall, then issue
        prod(5'd3, LD);                     chk(0, 0, 0);
        drive(1, 5'd3, 1, 5'd1, 1, 0, 1, 5'd4, ALU, 0, 0);
        chk(1, b(3), 0);
        chk(0, 0, 1);

        // store data from load: no stall; load as base: one stall
        prod(5'd3, LD);                     chk(0, 0, 1);
        drive(1, 5'd5, 1, 5'd3, 1, 1, 0, 5'd0, ALU, 0, 0);
        chk(0, b(3), 1);
        prod(5'd3, LD);                     chk(0, 0, 1);
        drive(1, 5'd3, 1, 5'd6, 1, 1, 0, 5'd0, ALU, 0, 0);
        chk(1, b(3), 1);
        chk(0, 0, 2);

        // multiply: four stalls
        prod(5'd7, MUL);                    chk(0, 0, 2);
        dep(5'd7, 5'd8, 0, 0);
        chk(1, b(7), 2); chk(1, b(7), 3); chk(1, b(7), 4); chk(1, b(7), 5);
        chk(0, 0, 6);

        // multiply with mem_busy freeze of 3 cycles
        prod(5'd7, MUL);                    chk(0, 0, 6);
        dep(5'd7, 5'd8, 0, 0);              chk(1, b(7), 6);
        dep(5'd7, 5'd8, 0, 1);              chk(1, b(7), 7); chk(1, b(7), 8); chk(1, b(7), 9);
        dep(5'd7, 5'd8, 0, 0);              chk(1, b(7), 10); chk(1, b(7), 11); chk(1, b(7), 12);
        chk(0, 0, 13);

        // WAW: mul r2 then load r2 keeps the longer count
        prod(5'd2, MUL);                    chk(0, 0, 13);
        prod(5'd2, LD);                     chk(0, b(2), 13);
        dep(5'd2, 5'd9, 0, 0);              chk(1, b(2), 13); chk(1, b(2), 14); chk(1, b(2), 15);
        chk(0, 0, 16);

        // r0 is never busy
        prod(5'd0, LD);                     chk(0, 0, 16);
        dep(5'd0, 5'd9, 0, 0);              chk(0, 0, 16);

        // reset mid-countdown with dependent waiting
        prod(5'd5, MUL);                    chk(0, 0, 16);
        idle(1'b0);                         chk(0, b(5), 16);
        dep(5'd5, 5'd10, 0, 0);             chk(1, b(5), 16);
        reset = 1'b1;                       chk(1, b(5), 17);
        reset = 1'b0;                       chk(0, 0, 0);

        // flush drops the stall; the pending count keeps running
        prod(5'd6, MUL);                    chk(0, 0, 0);
        dep(5'd6, 5'd11, 1, 0);             chk(0, b(6), 0);
        dep(5'd6, 5'd11, 0, 0);             chk(1, b(6), 0);
        dep(5'd6, 5'd11, 1, 0);             chk(0, b(6), 1);
        idle(1'b0);                         chk(0, b(6), 1);
        chk(0, 0, 1);

        // mem_busy alone stalls
        idle(1'b1);                         chk(1, 0, 1);
        idle(1'b0);                         chk(0, 0, 2);

        // source equals destination: hazard uses pre-issue count
        drive(1, 5'd12, 1, 5'd0, 0, 0, 1, 5'd12, MUL, 0, 0);
        chk(0, 0, 2);
        idle(1'b0);                         chk(0, b(12), 2);

        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
